// File: rtl/mul_row_emitter.sv
// mul_row_emitter: streams A[i]*b_j partial-product pairs per multiplier word, LS word first.
// Define MUL_ROW_EMITTER_STALL_CNT_EN to add the saturating stall_count_out counter.
module mul_row_emitter #(
  parameter int register_size   = 32,
  parameter int num_bits_stored = 2048,
  parameter int desired_size    = 2080
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [register_size-1:0]          a_data_in,
  input  logic                              a_valid_in,
  output logic                              a_ready_out,
  input  logic [register_size-1:0]          b_data_in,
  input  logic                              b_valid_in,
  output logic                              b_ready_out,
  output logic [register_size-1:0]          high_out,
  output logic [register_size-1:0]          low_out,
  output logic [$clog2(desired_size):0]     padding_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic                              row_done_out
`ifdef MUL_ROW_EMITTER_STALL_CNT_EN
  ,
  output logic [31:0]                       stall_count_out
`endif
);
  localparam int RS = register_size;
  localparam int NW = num_bits_stored / register_size;
  localparam int IW = $clog2(NW);
  localparam int PW = $clog2(desired_size) + 1;
  localparam logic [IW-1:0] LAST = IW'(NW - 1);
  typedef enum logic [1:0] {LOAD_A, WAIT_B, EMIT, DRAIN} state_t;
  state_t state;
  logic [RS-1:0] mem [NW];
  logic [RS-1:0] b, rd;
  logic [IW-1:0] idx, row;
  logic [2*RS-1:0] e0, e1, p;
  logic [1:0] count;
  logic s1_v, pop, push, issue, empty, we;
  assign {high_out, low_out} = e0;
  assign valid_out = count != 2'd0;
  assign pop = valid_out && ready_in;
  assign push = s1_v;
  assign empty = !s1_v && count == 2'd0;
  assign we = state == LOAD_A && a_valid_in && a_ready_out;
  // The pair leaving this cycle frees its slot, which is what sustains one issue per cycle.
  assign issue = state == EMIT && (3'(s1_v) + 3'(count) - 3'(pop)) < 3'd2;
  assign p = {{RS{1'b0}}, rd} * {{RS{1'b0}}, b};
  always_ff @(posedge clk_in) begin
    if (we) mem[idx] <= a_data_in;
    if (issue) rd <= mem[idx];
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= LOAD_A;
      idx <= '0;
      row <= '0;
      b <= '0;
      padding_out <= '0;
      a_ready_out <= 1'b0;
      b_ready_out <= 1'b0;
      row_done_out <= 1'b0;
      s1_v <= 1'b0;
      count <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      row_done_out <= 1'b0;
      s1_v <= issue;
      count <= count + 2'(push) - 2'(pop);
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) e0 <= p;
      else if (pop && count == 2'd2) e0 <= e1;
      if (push && count == 2'd1 && !pop) e1 <= p;
      case (state)
        LOAD_A: begin
          a_ready_out <= 1'b1;
          if (we) begin
            idx <= idx + IW'(1);
            if (idx == LAST) begin
              state <= WAIT_B;
              idx <= '0;
              row <= '0;
              a_ready_out <= 1'b0;
              b_ready_out <= 1'b1;
            end
          end
        end
        WAIT_B: if (b_valid_in && b_ready_out) begin
          b <= b_data_in;
          padding_out <= PW'(row);
          b_ready_out <= 1'b0;
          state <= EMIT;
        end
        EMIT: if (issue) begin
          idx <= idx + IW'(1);
          if (idx == LAST) begin
            idx <= '0;
            state <= DRAIN;
          end
        end
        default: if (empty) begin
          row_done_out <= 1'b1;
          row <= row + IW'(1);
          if (row == LAST) begin
            row <= '0;
            state <= LOAD_A;
            a_ready_out <= 1'b1;
          end else begin
            state <= WAIT_B;
            b_ready_out <= 1'b1;
          end
        end
      endcase
    end
  end
`ifdef MUL_ROW_EMITTER_STALL_CNT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) stall_count_out <= '0;
    else if (state == DRAIN && empty && row == LAST) stall_count_out <= '0;
    else if (valid_out && !ready_in && stall_count_out != '1) stall_count_out <= stall_count_out + 32'd1;
  end
`endif
endmodule
